irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- NIRQ, 6, number of hardware interrupt lines (MIPS IM[7:2]).
- BASE, 32'h0000_7f20, device window base address.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock; all state changes on posedge.
- reset, in, 1, asynchronous, active-high reset.
- hw_irq, in, NIRQ, device interrupt lines, bit0 highest priority.
- im, in, NIRQ, CP0 SR mask bits.
- ie, in, 1, CP0 SR global interrupt enable.
- exl, in, 1, CP0 SR EXL bit.
- exl_set, in, 1, controller entered INT state (EXLSet).
- exl_clr, in, 1, controller executing eret (EXLClr).
- dev_addr, in, 32, CPU data-bus byte address.
- dev_wen, in, 1, CPU device write strobe.
- dev_wdata, in, 32, write data.
- dev_rdata, out, 32, read data, combinational from dev_addr.
- int_req, out, 1, interrupt request to controller (IntReq).
- int_id, out, 3, captured index of the serviced line.
- ip, out, NIRQ, pending bits for CP0 Cause.IP.

Function
REQ-003 Registers at BASE+0 PEND (RO, or W1C under config), BASE+4 MASK (RW, NIRQ bits), BASE+8 ID (RO, {29'b0,int_id}); other offsets SHALL read 0 and ignore writes.
REQ-004 A write SHALL take effect only when dev_wen=1 and dev_addr[31:4]==BASE[31:4]; dev_addr[1:0] SHALL be ignored.
REQ-005 qual = PEND & MASK & im; any_q = |qual & ie & !exl.
REQ-006 ip SHALL equal PEND.
REQ-007 FSM states: IDLE, REQ, SERV.
REQ-008 IDLE->REQ when any_q=1.
REQ-009 REQ->SERV on exl_set.
REQ-010 REQ->IDLE when any_q=0 and exl_set=0.
REQ-011 SERV->IDLE on exl_clr.
REQ-012 int_req SHALL be registered and equal 1 exactly while in REQ; assertion lands 1 cycle after any_q first rises.
REQ-013 On REQ->SERV, int_id SHALL capture the lowest set index of qual; it SHALL hold until the next capture.
REQ-014 exl_set in IDLE/SERV, and exl_clr in IDLE/REQ, SHALL be ignored.
REQ-015 Simultaneous exl_set and exl_clr in REQ SHALL take REQ->SERV.
REQ-016 MASK write clearing all qualifying bits while in REQ SHALL drop int_req on the following cycle.

Reset
REQ-017 On reset (asynchronous assert, synchronous release), the following SHALL hold: state=IDLE, int_req=0, int_id=0, PEND=0, MASK={NIRQ{1'b1}}, and the edge history register=0.
REQ-018 Reset mid-REQ or mid-SERV SHALL abandon service with no residual request.

Configuration
REQ-019 The block SHALL support the macro IRQ_EDGE_EN. When it is defined:
- PEND[i] SHALL set on a 0->1 transition of hw_irq[i], sampled via a 1-stage history register.
- Writing 1 to a PEND bit SHALL clear it.
- When a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-020 When IRQ_EDGE_EN is undefined:
- PEND SHALL be a registered copy of hw_irq (1-cycle delay).
- Writes to PEND SHALL be ignored.
- The history register SHALL be absent.

Structure
REQ-021 Package irq_pkg SHALL hold:
- the state enum (IDLE=2'd0, REQ=2'd1, SERV=2'd2);
- register offsets (PEND_OFS=4'h0, MASK_OFS=4'h4, ID_OFS=4'h8);
- NIRQ_DEF=6.
REQ-022 The lowest-index priority encoder SHALL be the sub-module irq_prio_enc (NIRQ in, index plus valid out, purely combinational).

Verification
REQ-023 Level mode: hw_irq=6'b000100, im=all 1, ie=1, exl=0 -> ip=000100 at cycle 1, int_req=1 at cycle 2; pulse exl_set -> int_req=0 next cycle and int_id=2.
REQ-024 Priority: hw_irq=6'b101000 simultaneous -> int_id=3; after exl_clr, with bit3 dropped -> new REQ, exl_set -> int_id=5.
REQ-025 Masking: im=6'b111011 with hw_irq=6'b000100 -> int_req stays 0 for 20 cycles; then write MASK=0 after setting im=all 1 -> int_req stays 0.
REQ-026 Edge mode: 1-cycle pulse on hw_irq[1] -> PEND=000010 persists; W1C write 32'h2 to BASE+0 -> PEND=0; pulse and W1C in the same cycle -> PEND[1]=1.
REQ-027 Reset asserted asynchronously while in SERV -> int_req=0, int_id=0, and MASK reads 32'h3f immediately; no request after release until a new qualifying irq.
REQ-028 exl=1 while hw_irq active -> int_req=0; exl falls -> int_req=1 one cycle later.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and register map for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } irq_state_e;

  localparam logic [3:0] PEND_OFS = 4'h0;
  localparam logic [3:0] MASK_OFS = 4'h4;
  localparam logic [3:0] ID_OFS   = 4'h8;

  localparam int unsigned NIRQ_DEF = 6;

  // Word offset inside the 16-byte window; byte lane bits are dropped.
  function automatic logic [3:0] reg_ofs(input logic [1:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder, purely combinational.
module irq_prio_enc #(
  parameter int unsigned N    = 6,
  parameter int unsigned IdxW = 3
) (
  input  logic [N-1:0]    req,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  // Scan from the top down so the lowest set bit is the last write.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IdxW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// MIPS-style interrupt controller: pending/mask registers, request FSM, serviced-line capture.
// Define IRQ_EDGE_EN for edge-triggered PEND with write-1-to-clear; default is level mode.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NIRQ = NIRQ_DEF,
  parameter logic [31:0] BASE = 32'h0000_7f20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] hw_irq,
  input  logic [NIRQ-1:0] im,
  input  logic            ie,
  input  logic            exl,
  input  logic            exl_set,
  input  logic            exl_clr,
  input  logic [31:0]     dev_addr,
  input  logic            dev_wen,
  input  logic [31:0]     dev_wdata,
  output logic [31:0]     dev_rdata,
  output logic            int_req,
  output logic [2:0]      int_id,
  output logic [NIRQ-1:0] ip
);

  irq_state_e      state_q, state_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [2:0]      int_id_q, int_id_d;
  logic            int_req_q;

  logic            win_hit;
  logic [3:0]      ofs;
  logic            wr_pend, wr_mask;
  logic [NIRQ-1:0] qual;
  logic            any_qual;
  logic [2:0]      enc_idx;
  logic            enc_valid;

  assign win_hit = (dev_addr[31:4] == BASE[31:4]);
  assign ofs     = reg_ofs(dev_addr[3:2]);
  assign wr_pend = dev_wen && win_hit && (ofs == PEND_OFS);
  assign wr_mask = dev_wen && win_hit && (ofs == MASK_OFS);

  logic unused_bits;
  assign unused_bits = ^{dev_wdata[31:NIRQ], dev_addr[1:0], wr_pend};

  // ---------------------------------------------------------------------------
  // Pending register
  // ---------------------------------------------------------------------------
`ifdef IRQ_EDGE_EN
  logic [NIRQ-1:0] hist_q;
  logic [NIRQ-1:0] pend_w1c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= '0;
    else       hist_q <= hw_irq;
  end

  assign pend_w1c = wr_pend ? dev_wdata[NIRQ-1:0] : '0;
  // A rising edge in the same cycle as a clear keeps the bit set.
  assign pend_d   = (pend_q & ~pend_w1c) | (hw_irq & ~hist_q);
`else
  assign pend_d = hw_irq;
`endif

  assign mask_d = wr_mask ? dev_wdata[NIRQ-1:0] : mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      mask_q <= '1;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Qualification and priority
  // ---------------------------------------------------------------------------
  assign qual     = pend_q & mask_q & im;
  assign any_qual = (|qual) && ie && !exl;

  irq_prio_enc #(
    .N    (NIRQ),
    .IdxW (3)
  ) u_prio_enc (
    .req   (qual),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    int_id_d = int_id_q;
    case (state_q)
      IDLE: begin
        if (any_qual) state_d = REQ;
      end
      REQ: begin
        // exl_set takes priority over a dropped request and over exl_clr.
        if (exl_set) begin
          state_d  = SERV;
          int_id_d = enc_valid ? enc_idx : 3'd0;
        end else if (!any_qual) begin
          state_d = IDLE;
        end
      end
      SERV: begin
        if (exl_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      int_id_q  <= 3'd0;
      int_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_id_q  <= int_id_d;
      int_req_q <= (state_d == REQ);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs and register readback
  // ---------------------------------------------------------------------------
  assign int_req = int_req_q;
  assign int_id  = int_id_q;
  assign ip      = pend_q;

  always_comb begin
    dev_rdata = 32'd0;
    if (win_hit) begin
      case (ofs)
        PEND_OFS: dev_rdata = 32'(pend_q);
        MASK_OFS: dev_rdata = 32'(mask_q);
        ID_OFS:   dev_rdata = {29'd0, int_id_q};
        default:  dev_rdata = 32'd0;
      endcase
    end
  end

endmodule
